// File: rtl/myspi_master.sv
// SPI mode-0 initiator: one 32-bit {write, addr, data} frame per request, MSB first.
// Define MYSPI_MASTER_VERIFY_EN to follow each write with a read-back frame and flag mismatches.
module myspi_master #(
   parameter int unsigned CLK_DIV  = 8,
   parameter int unsigned CS_SETUP = 8,
   parameter int unsigned CS_GAP   = 8
) (
   input  logic        theClock,
   input  logic        theReset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [14:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        spi_cs_n,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam logic [15:0] SetupLast = 16'(CS_SETUP - 1);
   localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
   // Final SCLK low phase plus CS hold time, both with SCLK low and CS asserted.
   localparam logic [15:0] HoldLast  = 16'(2 * CLK_DIV - 1);
   localparam logic [15:0] GapLast   = 16'(CS_GAP - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] shreg_q, shreg_d;
   logic [4:0]  bitcnt_q, bitcnt_d;
   logic [15:0] rx_q, rx_d;
   logic        miso_s1_q, miso_s2_q;
   logic        cs_n_q, cs_n_d;
   logic        clk_q, clk_d;
   logic        mosi_q, mosi_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        accept;
`ifdef MYSPI_MASTER_VERIFY_EN
   logic        wr_q, wr_d;
   logic        verify_q, verify_d;
   logic [14:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
`endif

   assign req_ready = (state_q == StIdle);
   assign busy      = ~req_ready;
   assign accept    = req_valid & req_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_clk   = clk_q;
   assign spi_mosi  = mosi_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 16'd1;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      rx_d        = rx_q;
      cs_n_d      = cs_n_q;
      clk_d       = clk_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef MYSPI_MASTER_VERIFY_EN
      wr_d        = wr_q;
      verify_d    = verify_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
`endif
      unique case (state_q)
         StIdle: begin
            cnt_d = 16'd0;
            if (accept) begin
               shreg_d  = {req_write, req_addr, req_write ? req_wdata : 16'h0};
               bitcnt_d = 5'd31;
               cs_n_d   = 1'b0;
               mosi_d   = req_write;
               state_d  = StSetup;
`ifdef MYSPI_MASTER_VERIFY_EN
               wr_d     = req_write;
               verify_d = 1'b0;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
`endif
            end
         end
         StSetup: begin
            if (cnt_q == SetupLast) begin
               cnt_d   = 16'd0;
               clk_d   = 1'b1;
               state_d = StHigh;
            end
         end
         StHigh: begin
            if (cnt_q == DivLast) begin
               cnt_d = 16'd0;
               clk_d = 1'b0;
               if (bitcnt_q == 5'd0) begin
                  state_d = StHold;
               end else begin
                  shreg_d  = {shreg_q[30:0], 1'b0};
                  bitcnt_d = bitcnt_q - 5'd1;
                  mosi_d   = shreg_q[30];
                  state_d  = StLow;
               end
            end
         end
         StLow: begin
            if (cnt_q == DivLast) begin
               cnt_d   = 16'd0;
               clk_d   = 1'b1;
               state_d = StHigh;
               // Only the data-word bits (rises 17..32) are kept.
               if (!bitcnt_q[4]) rx_d = {rx_q[14:0], miso_s2_q};
            end
         end
         StHold: begin
            if (cnt_q == HoldLast) begin
               cnt_d   = 16'd0;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               state_d = StGap;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d       = 16'd0;
               state_d     = StDone;
               rsp_rdata_d = rx_q;
`ifdef MYSPI_MASTER_VERIFY_EN
               rsp_err_d   = verify_q && (rx_q != wdata_q);
               if (wr_q && !verify_q) begin
                  verify_d    = 1'b1;
                  shreg_d     = {1'b0, addr_q, 16'h0};
                  bitcnt_d    = 5'd31;
                  cs_n_d      = 1'b0;
                  mosi_d      = 1'b0;
                  state_d     = StSetup;
                  rsp_rdata_d = rsp_rdata_q;
                  rsp_err_d   = rsp_err_q;
               end
`endif
            end
         end
         StDone: begin
            cnt_d       = 16'd0;
            rsp_valid_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge theClock) begin
      if (theReset) begin
         state_q     <= StIdle;
         cnt_q       <= 16'd0;
         shreg_q     <= 32'd0;
         bitcnt_q    <= 5'd0;
         rx_q        <= 16'd0;
         miso_s1_q   <= 1'b0;
         miso_s2_q   <= 1'b0;
         cs_n_q      <= 1'b1;
         clk_q       <= 1'b0;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'd0;
         rsp_err_q   <= 1'b0;
`ifdef MYSPI_MASTER_VERIFY_EN
         wr_q        <= 1'b0;
         verify_q    <= 1'b0;
         addr_q      <= 15'd0;
         wdata_q     <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         rx_q        <= rx_d;
         miso_s1_q   <= spi_miso;
         miso_s2_q   <= miso_s1_q;
         cs_n_q      <= cs_n_d;
         clk_q       <= clk_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef MYSPI_MASTER_VERIFY_EN
         wr_q        <= wr_d;
         verify_q    <= verify_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
`endif
      end
   end

endmodule

// File: tb/tb_myspi_master.sv
// Bench for myspi_master paired with a behavioural SPI register slave (mode 0).
// Honours MYSPI_MASTER_VERIFY_EN so the same vectors cover both builds.
module tb_myspi_master;

   logic        theClock = 1'b0;
   logic        theReset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [14:0] req_addr = 15'h0;
   logic [15:0] req_wdata = 16'h0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        spi_cs_n;
   logic        spi_clk;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;

`ifdef MYSPI_MASTER_VERIFY_EN
   localparam bit Verify = 1'b1;
`else
   localparam bit Verify = 1'b0;
`endif
   localparam int LatFrame = 537;
   localparam int LatVerifyWr = 537 + 536;

   int n_cmp = 0;
   int n_fail = 0;

   myspi_master dut (
      .theClock (theClock),
      .theReset (theReset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .spi_cs_n (spi_cs_n),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   initial forever #5 theClock = ~theClock;

   // Slave register file: 0x001 = Status (read-only), 0x010 = IO_A input (read-only).
   logic [15:0] regs [32];
   logic [15:0] status_val = 16'h1234;
   logic        io_a = 1'b0;
   logic [31:0] frames [$];
   int          cs_falls = 0;
   int          last_gap = 0;
   int          sl_cnt = 0;

   function automatic logic [15:0] reg_read(input logic [14:0] a);
      if (a == 15'h001) return status_val;
      if (a == 15'h010) return {15'h0, io_a};
      return regs[a[4:0]];
   endfunction

   initial begin
      logic        prev_clk = 1'b0;
      logic        prev_cs = 1'b1;
      logic [31:0] sh = 32'h0;
      logic [15:0] tx = 16'h0;
      int          hi_run = 0;
      for (int i = 0; i < 32; i++) regs[i] = 16'h0;
      forever begin
         @(negedge theClock);
         if (spi_cs_n) begin
            hi_run++;
         end else if (prev_cs) begin
            cs_falls++;
            last_gap = hi_run;
            hi_run = 0;
            sl_cnt = 0;
            spi_miso = 1'b0;
         end
         if (!spi_cs_n && !prev_cs) begin
            if (spi_clk && !prev_clk) begin
               sh = {sh[30:0], spi_mosi};
               sl_cnt++;
               if (sl_cnt == 16) tx = reg_read(sh[14:0]);
               if (sl_cnt == 32) begin
                  frames.push_back(sh);
                  if (sh[31] && sh[30:16] != 15'h001 && sh[30:16] != 15'h010)
                     regs[sh[20:16]] = sh[15:0];
               end
            end
            if (!spi_clk && prev_clk) begin
               if (sl_cnt >= 16 && sl_cnt < 32) spi_miso = tx[31 - sl_cnt];
               else spi_miso = 1'b0;
            end
         end
         prev_clk = spi_clk;
         prev_cs = spi_cs_n;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(input string name, output int lat);
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 3000) begin
         @(posedge theClock);
         #1;
         lat++;
      end
      if (lat >= 3000) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: rsp_valid not seen within 3000 cycles", name);
      end
   endtask

   // Accept one request, scramble the request bus, wait for the response.
   task automatic run_txn(input string name, input logic w, input logic [14:0] a,
                          input logic [15:0] d, output int lat);
      @(negedge theClock);
      check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      @(posedge theClock);
      #1;
      req_valid = 1'b0;
      req_write = ~w;
      req_addr  = 15'h7fff;
      req_wdata = 16'hdead;
      frames.delete();
      wait_rsp(name, lat);
   endtask

   typedef struct {
      string       name;
      logic        wr;
      logic [14:0] addr;
      logic [15:0] wdata;
      logic [31:0] mosi;
      logic [15:0] rd_plain;
      logic [15:0] rd_verify;
      logic        err_verify;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int lat;
      int seen;
      int exp_lat;
      int exp_frames;
      logic [15:0] exp_rd;
      logic        exp_err;

      vecs[0] = '{"wr_led",     1'b1, 15'h002, 16'h00A5, 32'h800200A5, 16'h0000, 16'h00A5, 1'b0};
      vecs[1] = '{"rd_status",  1'b0, 15'h001, 16'hFFFF, 32'h00010000, 16'h1234, 16'h1234, 1'b0};
      vecs[2] = '{"wr_beef",    1'b1, 15'h011, 16'hBEEF, 32'h8011BEEF, 16'h0000, 16'hBEEF, 1'b0};
      vecs[3] = '{"rd_beef",    1'b0, 15'h011, 16'h5A5A, 32'h00110000, 16'hBEEF, 16'hBEEF, 1'b0};
      vecs[4] = '{"wr_zero",    1'b1, 15'h011, 16'h0000, 32'h80110000, 16'hBEEF, 16'h0000, 1'b0};
      vecs[5] = '{"wr_r0",      1'b1, 15'h000, 16'h0003, 32'h80000003, 16'h0000, 16'h0003, 1'b0};
      vecs[6] = '{"wr_ioa",     1'b1, 15'h010, 16'h0001, 32'h80100001, 16'h0000, 16'h0000, 1'b1};
      vecs[7] = '{"rd_ioa",     1'b0, 15'h010, 16'h0000, 32'h00100000, 16'h0000, 16'h0000, 1'b0};

      // Reset state.
      repeat (3) @(posedge theClock);
      #1;
      check("rst_cs_n",  {31'h0, spi_cs_n},  32'h1);
      check("rst_clk",   {31'h0, spi_clk},   32'h0);
      check("rst_mosi",  {31'h0, spi_mosi},  32'h0);
      check("rst_valid", {31'h0, rsp_valid}, 32'h0);
      check("rst_rdata", {16'h0, rsp_rdata}, 32'h0);
      check("rst_err",   {31'h0, rsp_err},   32'h0);
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_busy",  {31'h0, busy},      32'h0);
      theReset = 1'b0;
      repeat (2) @(posedge theClock);

      for (int i = 0; i < 8; i++) begin
         exp_rd     = Verify ? vecs[i].rd_verify : vecs[i].rd_plain;
         exp_err    = Verify ? vecs[i].err_verify : 1'b0;
         exp_lat    = (Verify && vecs[i].wr) ? LatVerifyWr : LatFrame;
         exp_frames = (Verify && vecs[i].wr) ? 2 : 1;
         run_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
         check({vecs[i].name, "_lat"},    lat, exp_lat);
         check({vecs[i].name, "_rdata"},  {16'h0, rsp_rdata}, {16'h0, exp_rd});
         check({vecs[i].name, "_err"},    {31'h0, rsp_err}, {31'h0, exp_err});
         check({vecs[i].name, "_frames"}, frames.size(), exp_frames);
         if (frames.size() > 0) check({vecs[i].name, "_mosi"}, frames[0], vecs[i].mosi);
         if (frames.size() > 1)
            check({vecs[i].name, "_vmosi"}, frames[1], {1'b0, vecs[i].addr, 16'h0});
         @(posedge theClock);
         #1;
         check({vecs[i].name, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
      end
      check("led70_reg", {16'h0, regs[2]}, 32'h00A5);

      // Back-to-back: req_valid held, second write accepted on the rsp_valid cycle.
      @(negedge theClock);
      req_write = 1'b1;
      req_addr  = 15'h003;
      req_wdata = 16'h1111;
      req_valid = 1'b1;
      @(posedge theClock);
      #1;
      req_addr  = 15'h004;
      req_wdata = 16'h2222;
      wait_rsp("b2b_first", lat);
      check("b2b_ready_on_rsp", {31'h0, req_ready}, 32'h1);
      @(posedge theClock);
      #1;
      req_valid = 1'b0;
      check("b2b_busy", {31'h0, busy}, 32'h1);
      repeat (3) @(negedge theClock);
      check("b2b_cs_gap", {31'h0, (last_gap >= 8)}, 32'h1);
      wait_rsp("b2b_second", lat);
      check("b2b_reg3", {16'h0, regs[3]}, 32'h1111);
      check("b2b_reg4", {16'h0, regs[4]}, 32'h2222);

      // Reset during the HIGH phase of bit 10 (rise 22) of a write to 0x005.
      @(negedge theClock);
      req_write = 1'b1;
      req_addr  = 15'h005;
      req_wdata = 16'h5555;
      req_valid = 1'b1;
      @(posedge theClock);
      #1;
      req_valid = 1'b0;
      seen = 0;
      while (!(sl_cnt == 22 && spi_clk) && seen < 2000) begin
         @(negedge theClock);
         seen++;
      end
      check("abort_reached_bit10", {31'h0, (seen < 2000)}, 32'h1);
      check("abort_busy", {31'h0, busy}, 32'h1);
      theReset = 1'b1;
      @(posedge theClock);
      #1;
      check("abort_cs_n",  {31'h0, spi_cs_n},  32'h1);
      check("abort_clk",   {31'h0, spi_clk},   32'h0);
      check("abort_mosi",  {31'h0, spi_mosi},  32'h0);
      check("abort_ready", {31'h0, req_ready}, 32'h1);
      @(negedge theClock);
      theReset = 1'b0;
      seen = 0;
      for (int c = 0; c < 700; c++) begin
         @(posedge theClock);
         #1;
         if (rsp_valid) seen++;
      end
      check("abort_no_rsp", seen, 0);
      check("abort_reg5", {16'h0, regs[5]}, 32'h0);

      // Operation resumes after the abort.
      run_txn("post_abort_rd", 1'b0, 15'h005, 16'h0, lat);
      check("post_abort_lat", lat, LatFrame);
      check("post_abort_rdata", {16'h0, rsp_rdata}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
